// File: rtl/key_mode_controller_pkg.sv
// Shared defaults and debounce state encoding for the key/mode front end.
package key_mode_controller_pkg;

    localparam int DEF_NUM_MODES       = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 500000;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_t;

endpackage

// File: rtl/key_mode_controller_if.sv
// Board-facing bundle: raw active-low keys in, mode select and key events out.
interface key_mode_controller_if;
  logic [1:0] KEY;
  logic [3:0] module_select;
  logic       step_up;
  logic       step_down;
  logic [1:0] key_state;

  modport master (
    output KEY,
    input  module_select, step_up, step_down, key_state
  );

  modport slave (
    input  KEY,
    output module_select, step_up, step_down, key_state
  );
endinterface

// File: rtl/key_mode_controller_key_debounce.sv
// One key: two-flop synchroniser, debounce FSM, registered one-cycle press pulse.
// Pulse arrives DEBOUNCE_CYCLES+2 edges after the first low sample; no backpressure.
module key_debounce
  import key_mode_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic level,
  output logic press_pulse
);

  localparam int                CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1, sync2;
  logic             pressed_s;
  db_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pulse_nxt;

  // Synchroniser resets to the released level so a reset never looks like a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  assign pressed_s = ~sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      press_pulse <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      press_pulse <= pulse_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pulse_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (pressed_s) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!pressed_s) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = PRESSED;
          pulse_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!pressed_s) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        // A bounce back to pressed re-enters PRESSED silently: no auto-repeat.
        if (pressed_s) begin
          state_nxt = PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    level = (state == PRESSED) || (state == RELEASE_WAIT);
  end

endmodule

// File: rtl/key_mode_controller.sv
// Debounces KEY[0]/KEY[1] into step pulses and keeps the wrapping module-select register.
// module_select follows a step pulse by one edge; simultaneous pulses cancel.
module key_mode_controller
  import key_mode_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int NUM_MODES       = DEF_NUM_MODES
) (
  input  logic                 CLK,
  input  logic                 RESET,
  key_mode_controller_if.slave bus
);

  localparam int               SEL_W     = $clog2(NUM_MODES);
  localparam logic [SEL_W-1:0] MODE_LAST = SEL_W'(NUM_MODES - 1);

  logic [1:0]       level;
  logic [1:0]       pulse;
  logic [SEL_W-1:0] mode_q;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk        (CLK),
    .rst        (RESET),
    .key_raw    (bus.KEY[0]),
    .level      (level[0]),
    .press_pulse(pulse[0])
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk        (CLK),
    .rst        (RESET),
    .key_raw    (bus.KEY[1]),
    .level      (level[1]),
    .press_pulse(pulse[1])
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      mode_q <= '0;
    end else if (pulse == 2'b01) begin
      mode_q <= (mode_q == MODE_LAST) ? '0 : mode_q + SEL_W'(1);
    end else if (pulse == 2'b10) begin
      mode_q <= (mode_q == '0) ? MODE_LAST : mode_q - SEL_W'(1);
    end
  end

  // Register is only SEL_W wide, so the upper select bits are structurally zero.
  assign bus.module_select = 4'(mode_q);
  assign bus.step_up       = pulse[0];
  assign bus.step_down     = pulse[1];
  assign bus.key_state     = level;

endmodule

// File: tb/tb_key_mode_controller.sv
// Bench for key_mode_controller: run-length debounce model, per-cycle compare, directed literal checks.
module tb_key_mode_controller;

  localparam int D  = 4;
  localparam int NM = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  key_mode_controller_if kif ();

  key_mode_controller #(.DEBOUNCE_CYCLES(D), .NUM_MODES(NM)) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (kif)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model: a key's debounced level flips after D+1 consecutive synchronised samples disagreeing with it.
  bit [1:0] m_s1 = 2'b11, m_s2 = 2'b11, m_lvl = 2'b00;
  int       m_run[2] = '{0, 0};
  bit       m_up = 0, m_dn = 0;
  int       m_sel = 0;

  always @(posedge clk) begin
    bit nu[2];
    if (rst) begin
      m_s1 = 2'b11; m_s2 = 2'b11; m_lvl = 2'b00;
      m_run[0] = 0; m_run[1] = 0;
      m_up = 0; m_dn = 0; m_sel = 0;
    end else begin
      if (m_up && !m_dn)      m_sel = (m_sel + 1) % NM;
      else if (m_dn && !m_up) m_sel = (m_sel + NM - 1) % NM;
      for (int k = 0; k < 2; k++) begin
        bit p;
        p = !m_s2[k];
        nu[k] = 0;
        if (p != m_lvl[k]) begin
          m_run[k]++;
          if (m_run[k] == D + 1) begin
            m_lvl[k] = p;
            m_run[k] = 0;
            nu[k]    = p;
          end
        end else begin
          m_run[k] = 0;
        end
      end
      m_up = nu[0];
      m_dn = nu[1];
      m_s2 = m_s1;
      m_s1 = kif.KEY;
    end
  end

  int up_cnt = 0, dn_cnt = 0, chg_cnt = 0;
  int last_up = -1, last_dn = -1, last_chg = -1;
  int prev_sel = 0;

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("sel",       int'(kif.module_select), m_sel);
      check("step_up",   int'(kif.step_up),       int'(m_up));
      check("step_down", int'(kif.step_down),     int'(m_dn));
      check("key_state", int'(kif.key_state),     int'(m_lvl));
      if (kif.step_up)   begin up_cnt++; last_up = cyc; end
      if (kif.step_down) begin dn_cnt++; last_dn = cyc; end
      if (int'(kif.module_select) != prev_sel) begin chg_cnt++; last_chg = cyc; end
      prev_sel = int'(kif.module_select);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int k, input int len, input int gap);
    @(negedge clk);
    kif.KEY[k] = 1'b0;
    tick(len);
    kif.KEY[k] = 1'b1;
    tick(gap);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2);
  endtask

  initial begin
    int n, r1, s, u0, d0, c0;
    kif.KEY = 2'b11;
    rst     = 1'b1;
    tick(2);
    check("reset_sel",  int'(kif.module_select), 0);
    check("reset_up",   int'(kif.step_up),       0);
    check("reset_dn",   int'(kif.step_down),     0);
    check("reset_keys", int'(kif.key_state),     0);
    rst = 1'b0;
    tick(2);

    // Clean press: pulse observed after edge N+6, select changes at N+7.
    u0 = up_cnt;
    @(negedge clk);
    kif.KEY[0] = 1'b0;
    n = cyc + 1;
    tick(10);
    check("clean_level", int'(kif.key_state), 1);
    tick(10);
    kif.KEY[0] = 1'b1;
    tick(12);
    check("clean_pulse_cyc", last_up, n + 6);
    check("clean_sel_cyc",   last_chg, n + 7);
    check("clean_sel",       int'(kif.module_select), 1);
    check("clean_one_pulse", up_cnt - u0, 1);
    check("clean_released",  int'(kif.key_state), 0);

    // Forward wrap 1,2,3,0 from reset.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      press(0, 10, 12);
      check("wrap_up", int'(kif.module_select), (i + 1) % NM);
    end
    do_reset();
    press(1, 10, 12);
    check("wrap_down", int'(kif.module_select), 3);

    // Press bounce: two 3-sample low runs are both too short.
    s = int'(kif.module_select);
    u0 = up_cnt;
    @(negedge clk);
    kif.KEY[0] = 1'b0; tick(3);
    kif.KEY[0] = 1'b1; tick(1);
    kif.KEY[0] = 1'b0; tick(3);
    kif.KEY[0] = 1'b1; tick(12);
    check("bounce_no_pulse", up_cnt - u0, 0);
    check("bounce_sel",      int'(kif.module_select), s);
    check("bounce_keys",     int'(kif.key_state), 0);

    // Release bounce: a 2-cycle release while held must not re-trigger.
    u0 = up_cnt;
    @(negedge clk);
    kif.KEY[0] = 1'b0; tick(10);
    kif.KEY[0] = 1'b1; tick(2);
    kif.KEY[0] = 1'b0; tick(8);
    kif.KEY[0] = 1'b1; tick(12);
    check("rel_bounce_pulses", up_cnt - u0, 1);
    check("rel_bounce_sel",    int'(kif.module_select), (s + 1) % NM);

    // Simultaneous pulses cancel.
    s = int'(kif.module_select);
    u0 = up_cnt; d0 = dn_cnt; c0 = chg_cnt;
    @(negedge clk);
    kif.KEY = 2'b00; tick(10);
    kif.KEY = 2'b11; tick(12);
    check("simul_up",   up_cnt - u0, 1);
    check("simul_dn",   dn_cnt - d0, 1);
    check("simul_sel",  int'(kif.module_select), s);
    check("simul_chg",  chg_cnt - c0, 0);

    // Pulses one cycle apart: two updates, net zero.
    c0 = chg_cnt;
    @(negedge clk);
    kif.KEY[0] = 1'b0; tick(1);
    kif.KEY[1] = 1'b0; tick(10);
    kif.KEY = 2'b11; tick(12);
    check("apart_gap", last_dn - last_up, 1);
    check("apart_chg", chg_cnt - c0, 2);
    check("apart_sel", int'(kif.module_select), s);

    // Reset during PRESS_WAIT with KEY[1] held through deassertion.
    press(0, 10, 12);
    @(negedge clk);
    kif.KEY[1] = 1'b0;
    n = cyc + 1;
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    r1 = cyc + 1;
    check("mid_reset_sel", int'(kif.module_select), 0);
    check("mid_reset_keys", int'(kif.key_state), 0);
    tick(12);
    kif.KEY[1] = 1'b1;
    tick(12);
    check("mid_reset_dn_cyc", last_dn, r1 + 6);
    check("mid_reset_sel3",   int'(kif.module_select), 3);

    // Random key activity with occasional resets, checked by the model every cycle.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      kif.KEY = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick($urandom_range(0, 8));
    end
    kif.KEY = 2'b11;
    tick(15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/key_mode_controller.md
# key_mode_controller

Front-end input stage for the board top level: conditions the two raw push-buttons into clean, one-cycle press events and owns the module-select register that drives the HEX3 display and the output multiplexers. It replaces sampling an unsynchronised button edge as a clock with a fully synchronous, debounced design on the board clock. KEY[0] steps the mode forward and KEY[1] steps it backward, with wrap-around in both directions.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 500000, number of consecutive stable samples required to accept a press or release (10 ms at 50 MHz); legal range ≥ 2.
- NUM_MODES, 4, number of selectable modules; module_select counts 0..NUM_MODES-1; legal range 2..16.

Ports:
- CLK  in  1  board clock; the only clock.
- RESET  in  1  synchronous, active-high reset.
- KEY  in  2  raw push-buttons, active-low (0 = pressed), asynchronous to CLK.
- module_select  out  4  current mode, 0..NUM_MODES-1.
- step_up  out  1  one-cycle pulse on an accepted KEY[0] press.
- step_down  out  1  one-cycle pulse on an accepted KEY[1] press.
- key_state  out  2  debounced level per key, active-high (1 = held).

## Operation

- Per key: a two-flop synchroniser, then inversion to active-high pressed_s.
- Per-key debounce FSM with states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT and a counter sized ceil(log2(DEBOUNCE_CYCLES)):
  - IDLE: pressed_s=1 -> PRESS_WAIT, cnt<=0.
  - PRESS_WAIT: pressed_s=0 -> IDLE; else if cnt==DEBOUNCE_CYCLES-1 -> PRESSED and assert the press pulse; else cnt++.
  - PRESSED: pressed_s=0 -> RELEASE_WAIT, cnt<=0.
  - RELEASE_WAIT: pressed_s=1 -> PRESSED with no new pulse; else if cnt==DEBOUNCE_CYCLES-1 -> IDLE; else cnt++.
- key_state=1 in PRESSED and RELEASE_WAIT, and 0 otherwise.
- The press pulse is registered and asserted only on the PRESS_WAIT->PRESSED transition. It is never asserted while a key is held, so a held key does not auto-repeat.
- Mode register, evaluated on each edge:
  - step_up only: module_select <= (module_select==NUM_MODES-1) ? 0 : module_select+1.
  - step_down only: module_select <= (module_select==0) ? NUM_MODES-1 : module_select-1.
  - Both in the same cycle: hold.
  - Neither: hold.
- Bits of module_select at and above ceil(log2(NUM_MODES)) are always 0.

## Timing

- Reset values: module_select=0, step_up=0, step_down=0, key_state=2'b00, both FSMs in IDLE, counters 0, synchroniser flops at 1 (released).
- Press latency: KEY is first sampled low at edge N and held low. The pulse is high for exactly one cycle following edge N+DEBOUNCE_CYCLES+2. module_select updates at edge N+DEBOUNCE_CYCLES+3.
- Glitch rejection: any low run shorter than DEBOUNCE_CYCLES+1 synchronised samples produces no pulse and leaves key_state=0.
- Release bounce: bouncing during RELEASE_WAIT returns the FSM to PRESSED without a pulse. A new press is accepted only after IDLE has been reached.
- Reset mid-operation: all state returns to reset values at the edge where RESET=1. A key still held after RESET deasserts is treated as a new press and re-debounced with the full latency.
- Synchroniser flops are also reset. No combinational path exists from KEY to any output.

## Structure

- Shared package/header: NUM_MODES default, DEBOUNCE_CYCLES default, debounce state encoding (IDLE=2'd0, PRESS_WAIT=2'd1, PRESSED=2'd2, RELEASE_WAIT=2'd3).
- Sub-module key_debounce: synchroniser, FSM and counter for one key, with outputs level and press_pulse. It is instantiated twice.
- The top of this block holds only the mode register and its wrap logic.

## Test plan

All scenarios run with DEBOUNCE_CYCLES=4 and NUM_MODES=4.
- Reset: assert RESET with KEY=2'b11 -> module_select=0, step_up=step_down=0, key_state=0 on the next edge.
- Clean press: KEY[0] low from edge N for 20 cycles -> step_up high only in the cycle after edge N+6, module_select 0->1 at edge N+7, key_state[0]=1 while held.
- Wrap both ways:
  - Four accepted KEY[0] presses from 0 -> sequence 1,2,3,0.
  - One KEY[1] press from 0 -> module_select=3.
- Bounce: KEY[0] low 3 cycles, high 1, low 3, high -> no step_up, module_select unchanged. Release bounce of 2 cycles after a held press -> no second pulse.
- Simultaneous: both keys released from a common low, pulses in the same cycle -> module_select unchanged. Pulses one cycle apart -> net change 0 and exactly two updates observed.
- Reset mid-debounce: RESET during PRESS_WAIT with KEY[1] held through deassertion -> step_down occurs DEBOUNCE_CYCLES+2 edges after the first post-reset edge, and module_select goes from 0 to 3.
